// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_ctrl_pkg : shared types, widths and helpers for mem_ctrl      |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package mem_ctrl_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 7;
    localparam int DEF_DEPTH = 128;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Parity bit that makes the stored word plus the bit even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_ctrl_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_ctrl_array : word storage, sync write / comb read; optional   |
// |   parity column when MEM_CTRL_PARITY_EN is defined.               |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module mem_ctrl_array
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              perr_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  idx;

    // Upper address bits are dropped so accesses wrap modulo DEPTH.
    assign idx = addr_i[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[idx] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx];

`ifdef MEM_CTRL_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            par_q[idx] <= even_parity(wdata_i);
        end
    end

    assign perr_o = (even_parity(mem_q[idx]) != par_q[idx]);
`else
    assign perr_o = 1'b0;
`endif

endmodule : mem_ctrl_array
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_ctrl : single-port memory controller with WAIT_CYCLES wait    |
// |   states (IDLE/WAIT/ACK); MEM_CTRL_PARITY_EN enables perr.        |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              perr
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              perr_q, perr_d;
    logic              access;
    logic [DATA_W-1:0] arr_rdata;
    logic              arr_perr;

    mem_ctrl_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en_i (access & we_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata),
        .perr_o  (arr_perr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        perr_d  = 1'b0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Storage access edge; ready/perr are registered into ACK.
                    access  = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_ACK;
                    if (!we_q) begin
                        rdata_d = arr_rdata;
                        perr_d  = arr_perr;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = (state_q != ST_IDLE);
    assign perr  = perr_q;

endmodule : mem_ctrl
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_ctrl : self-checking bench; instance 0 WAIT_CYCLES=2,      |
// |   DEPTH=128; instance 1 WAIT_CYCLES=0, DEPTH=64 (address wrap).   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [6:0]  addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        ready_s [2];
    logic        busy_s  [2];
    logic        perr_s  [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [2][128];
    bit          vld [2][128];
    logic [31:0] exp_last [2];

    always #5 clk = ~clk;

    mem_ctrl #(.WAIT_CYCLES(2), .DEPTH(128)) u_a (
        .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]),
        .busy(busy_s[0]), .perr(perr_s[0])
    );

    mem_ctrl #(.WAIT_CYCLES(0), .DEPTH(64)) u_b (
        .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]),
        .busy(busy_s[1]), .perr(perr_s[1])
    );

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int idx_of(input int d, input logic [6:0] a);
        return (d == 0) ? int'(a) : (int'(a) % 64);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_rdata%0d", nm, d), rdata_s[d], 32'h0);
            chk($sformatf("%s_ready%0d", nm, d), {31'h0, ready_s[d]}, 32'h0);
            chk($sformatf("%s_busy%0d",  nm, d), {31'h0, busy_s[d]},  32'h0);
            chk($sformatf("%s_perr%0d",  nm, d), {31'h0, perr_s[d]},  32'h0);
        end
    endtask

    // One complete transaction with garbage (including req) driven while busy.
    task automatic access(input int d, input bit w, input logic [6:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input bit exp_pe, input string nm);
        int k;
        @(negedge clk);
        req_s[d] = 1'b1; we_s[d] = w; addr_s[d] = a; wdata_s[d] = wd;
        @(posedge clk); #1;
        req_s[d] = 1'b0; we_s[d] = 1'($urandom); addr_s[d] = 7'h10; wdata_s[d] = $urandom;
        chk({nm, "_busy"}, {31'h0, busy_s[d]}, 32'h1);
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (ready_s[d] === 1'b1) break;
            req_s[d] = 1'($urandom); we_s[d] = 1'($urandom); wdata_s[d] = $urandom;
        end
        chk({nm, "_latency"}, 32'(k), 32'(wc(d) + 1));
        chk({nm, "_rdata"}, rdata_s[d], exp_rd);
        chk({nm, "_perr"}, {31'h0, perr_s[d]}, {31'h0, exp_pe});
        chk({nm, "_ackbusy"}, {31'h0, busy_s[d]}, 32'h1);
        @(posedge clk); #1;
        req_s[d] = 1'b0;
        chk({nm, "_ready1cyc"}, {31'h0, ready_s[d]}, 32'h0);
        chk({nm, "_idle"}, {31'h0, busy_s[d]}, 32'h0);
        @(posedge clk); #1;
        chk({nm, "_noqueue"}, {31'h0, busy_s[d]}, 32'h0);
        if (w) begin
            mdl[d][idx_of(d, a)] = wd;
            vld[d][idx_of(d, a)] = 1'b1;
        end else begin
            exp_last[d] = exp_rd;
        end
    endtask

    typedef struct {
        int          d;
        bit          w;
        logic [6:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
        string       nm;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [15:0] seen;
        int          d;
        int          ix;
        logic [6:0]  a;
        logic [31:0] v;

        tbl[0] = '{0, 1'b1, 7'h05, 32'hDEADBEEF, 32'h00000000, "w2_wr05"};
        tbl[1] = '{0, 1'b0, 7'h05, 32'h0,        32'hDEADBEEF, "w2_rd05"};
        tbl[2] = '{0, 1'b1, 7'h7F, 32'hAAAA5555, 32'hDEADBEEF, "w2_wr7f"};
        tbl[3] = '{0, 1'b0, 7'h7F, 32'h0,        32'hAAAA5555, "w2_rd7f"};
        tbl[4] = '{0, 1'b0, 7'h05, 32'h0,        32'hDEADBEEF, "w2_rd05b"};
        tbl[5] = '{1, 1'b1, 7'h7F, 32'h12345678, 32'h00000000, "w0_wr7f"};
        tbl[6] = '{1, 1'b0, 7'h7F, 32'h0,        32'h12345678, "w0_rd7f"};
        tbl[7] = '{1, 1'b1, 7'h45, 32'hCAFEF00D, 32'h12345678, "w0_wr45"};
        tbl[8] = '{1, 1'b0, 7'h05, 32'h0,        32'hCAFEF00D, "w0_rd05wrap"};
        tbl[9] = '{1, 1'b0, 7'h3F, 32'h0,        32'h12345678, "w0_rd3fwrap"};

        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
            exp_last[i] = 32'h0;
            for (int j = 0; j < 128; j++) vld[i][j] = 1'b0;
        end
        rst = 1'b1;
        #2;
        chk_idle_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            access(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rd, 1'b0, tbl[i].nm);
        end

        // Back-to-back: req held high, one acceptance every WAIT_CYCLES+3 edges.
        @(negedge clk);
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 7'h05;
        @(posedge clk); #1;
        seen = '0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            seen[i] = ready_s[0];
            if (i == 14) req_s[0] = 1'b0;
        end
        chk("b2b_pulses", {16'h0, seen}, 32'h0000_2108);
        chk("b2b_rdata", rdata_s[0], mdl[0][5]);
        @(posedge clk); #1;
        chk("b2b_idle", {31'h0, busy_s[0]}, 32'h0);

        // Reset in WAIT aborts a pending write.
        access(0, 1'b1, 7'h03, 32'h0, exp_last[0], 1'b0, "w2_wr03zero");
        @(negedge clk);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 7'h03; wdata_s[0] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_wait");
        exp_last[0] = 32'h0; exp_last[1] = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        access(0, 1'b0, 7'h03, 32'h0, 32'h0, 1'b0, "w2_rd03_after_rst");

        // Reset during the ACK cycle clears ready and rdata at once.
        @(negedge clk);
        req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 7'h7F;
        @(posedge clk); #1;
        req_s[1] = 1'b0;
        @(posedge clk); #1;
        chk("ackrst_ready", {31'h0, ready_s[1]}, 32'h1);
        chk("ackrst_rdata", rdata_s[1], mdl[1][63]);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_ack");
        exp_last[0] = 32'h0; exp_last[1] = 32'h0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the array model.
        for (int n = 0; n < 40; n++) begin
            d  = int'($urandom_range(0, 1));
            a  = 7'($urandom);
            ix = idx_of(d, a);
            if ($urandom_range(0, 1) == 1 || !vld[d][ix]) begin
                v = $urandom;
                access(d, 1'b1, a, v, exp_last[d], 1'b0, $sformatf("rnd%0d_wr", n));
            end else begin
                access(d, 1'b0, a, 32'h0, mdl[d][ix], 1'b0, $sformatf("rnd%0d_rd", n));
            end
        end

`ifdef MEM_CTRL_PARITY_EN
        access(0, 1'b1, 7'h08, 32'h0F0F0F0F, exp_last[0], 1'b0, "par_wr08");
        u_a.u_array.mem_q[8] = u_a.u_array.mem_q[8] ^ 32'h0000_0001;
        mdl[0][8] = 32'h0F0F0F0E;
        access(0, 1'b0, 7'h08, 32'h0, 32'h0F0F0F0E, 1'b1, "par_rd08_err");
        access(0, 1'b0, 7'h05, 32'h0, mdl[0][5], 1'b0, "par_rd05_clean");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_ctrl
`default_nettype wire
